// File: rtl/reg_bank_write.sv
// Storage and write stage of the 8-entry register file.
// Single-cycle writes, plus a clear sequencer that loads CLR_VALUE into one
// register per cycle (reg0 first) while busy is high.
module reg_bank_write #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic             clr,
  output logic             busy,
  output logic             wr_rej,
  output logic [7:0]       wr_cnt,
  output logic [WIDTH-1:0] from_reg0,
  output logic [WIDTH-1:0] from_reg1,
  output logic [WIDTH-1:0] from_reg2,
  output logic [WIDTH-1:0] from_reg3,
  output logic [WIDTH-1:0] from_reg4,
  output logic [WIDTH-1:0] from_reg5,
  output logic [WIDTH-1:0] from_reg6,
  output logic [WIDTH-1:0] from_reg7
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic             accept;
  logic             reject;
  logic             clear_en;
  logic [WIDTH-1:0] regs [8];

  // State, pointer and status flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      busy   <= 1'b0;
      wr_rej <= 1'b0;
      wr_cnt <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      busy   <= (state_n == CLEAR);
      wr_rej <= reject;
      if (accept && (wr_cnt != 8'hFF))
        wr_cnt <= wr_cnt + 8'd1;
    end
  end

  // Next-state and write/clear arbitration; clr wins over a same-cycle write
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    accept   = 1'b0;
    reject   = 1'b0;
    clear_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          ptr_n   = '0;
          reject  = we;
        end else begin
          accept  = we;
        end
      end
      CLEAR: begin
        clear_en = 1'b1;
        ptr_n    = ptr + 3'd1;
        reject   = we;
        if (ptr == 3'd7)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Register array: accepted writes and progressive clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++)
        regs[i] <= '0;
    end else if (accept) begin
      regs[wAddr] <= wData;
    end else if (clear_en) begin
      regs[ptr] <= CLR_VALUE;
    end
  end

  assign from_reg0 = regs[0];
  assign from_reg1 = regs[1];
  assign from_reg2 = regs[2];
  assign from_reg3 = regs[3];
  assign from_reg4 = regs[4];
  assign from_reg5 = regs[5];
  assign from_reg6 = regs[6];
  assign from_reg7 = regs[7];

endmodule

// File: tb/tb_reg_bank_write.sv
// Self-checking bench for reg_bank_write against a cycle-level reference model.
module tb_reg_bank_write;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [2:0]    wAddr;
  logic [W-1:0]  wData;
  logic          clr;
  logic          busy;
  logic          wr_rej;
  logic [7:0]    wr_cnt;
  logic [W-1:0]  r0, r1, r2, r3, r4, r5, r6, r7;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m [8];
  int           cnt;
  int           clr_rem;
  logic         exp_rej;

  reg_bank_write #(.WIDTH(W), .CLR_VALUE('0)) dut (
    .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .clr(clr),
    .busy(busy), .wr_rej(wr_rej), .wr_cnt(wr_cnt),
    .from_reg0(r0), .from_reg1(r1), .from_reg2(r2), .from_reg3(r3),
    .from_reg4(r4), .from_reg5(r5), .from_reg6(r6), .from_reg7(r7)
  );

  always #5 clk = ~clk;

  logic [8*W+9:0] dut_state;
  assign dut_state = {busy, wr_rej, wr_cnt, r7, r6, r5, r4, r3, r2, r1, r0};

  function automatic logic [8*W+9:0] exp_state();
    logic [8*W-1:0] bank;
    for (int i = 0; i < 8; i++) bank[i*W +: W] = m[i];
    return {(clr_rem != 0), exp_rej, 8'(cnt), bank};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = '0;
    cnt = 0; clr_rem = 0; exp_rej = 1'b0;
  endtask

  // drive one cycle of inputs, advance model at the edge, settle past it
  task automatic step(input logic w, input logic [2:0] a, input logic [W-1:0] d,
                      input logic c);
    we = w; wAddr = a; wData = d; clr = c;
    @(posedge clk);
    if (clr_rem == 0) begin
      if (c) begin
        clr_rem = 8;
        exp_rej = w;
      end else begin
        exp_rej = 1'b0;
        if (w) begin
          m[a] = d;
          if (cnt < 255) cnt++;
        end
      end
    end else begin
      m[8 - clr_rem] = '0;
      clr_rem--;
      exp_rej = w;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 0; wAddr = 0; wData = 0; clr = 0;
    model_reset();
    #1;
    total++;
    if (dut_state !== exp_state()) begin
      bad++; $display("FAIL reset got=%h exp=%h", dut_state, exp_state());
    end
    #12 reset = 1'b0;
  endtask

  task automatic test_write_seq();
    logic [W-1:0] vals [8] = '{32'h12345678, 32'h13579bdf, 32'habcdef82, 32'h2385065d,
                               32'haaabbccd, 32'hffff222d, 32'h113239dc, 32'hccccffff};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), vals[i], 1'b0);
      total++;
      if (dut_state !== exp_state()) begin
        bad++; $display("FAIL write_seq[%0d] got=%h exp=%h", i, dut_state, exp_state());
      end
    end
    total++;
    if (wr_cnt !== 8'd8) begin
      bad++; $display("FAIL write_cnt got=%0d exp=8", wr_cnt);
    end
  endtask

  task automatic test_overwrite();
    step(1'b1, 3'd3, 32'hdeadbeef, 1'b0);
    total++;
    if (r3 !== 32'hdeadbeef || dut_state !== exp_state()) begin
      bad++; $display("FAIL overwrite_first got=%h exp=%h", dut_state, exp_state());
    end
    step(1'b1, 3'd3, 32'h00000001, 1'b0);
    total++;
    if (r3 !== 32'h1 || wr_cnt !== 8'd10 || dut_state !== exp_state()) begin
      bad++; $display("FAIL overwrite_second got=%h exp=%h", dut_state, exp_state());
    end
  endtask

  task automatic test_clear();
    step(1'b0, 3'd0, '0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      total++;
      if (dut_state !== exp_state()) begin
        bad++; $display("FAIL clear[%0d] got=%h exp=%h", k, dut_state, exp_state());
      end
      step(1'b0, 3'd0, '0, 1'b0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL clear_busy_end got=%b exp=0", busy);
    end
    step(1'b1, 3'd6, 32'hcafef00d, 1'b0);
    total++;
    if (r6 !== 32'hcafef00d || dut_state !== exp_state()) begin
      bad++; $display("FAIL clear_post_write got=%h exp=%h", dut_state, exp_state());
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), $urandom, 1'b0);
    step(1'b1, 3'd5, 32'h55555555, 1'b1);
    total++;
    if (wr_rej !== 1'b1 || dut_state !== exp_state()) begin
      bad++; $display("FAIL collide_start got=%h exp=%h", dut_state, exp_state());
    end
    for (int k = 0; k < 9; k++) begin
      step(k == 2, 3'd5, 32'h55555555, k < 4);
      total++;
      if (dut_state !== exp_state()) begin
        bad++; $display("FAIL collide[%0d] got=%h exp=%h", k, dut_state, exp_state());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), $urandom | 32'h1, 1'b0);
    step(1'b0, 3'd0, '0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, '0, 1'b0);
    #3 reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (dut_state !== exp_state()) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", dut_state, exp_state());
    end
    #2 reset = 1'b0;
    step(1'b1, 3'd7, 32'h0badf00d, 1'b0);
    total++;
    if (dut_state !== exp_state()) begin
      bad++; $display("FAIL async_reset_recover got=%h exp=%h", dut_state, exp_state());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 15) == 0);
      total++;
      if (dut_state !== exp_state()) begin
        bad++; $display("FAIL random[%0d] got=%h exp=%h", k, dut_state, exp_state());
      end
    end
    for (int k = 0; k < 9; k++) step(1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic test_saturation();
    reset = 1'b1; model_reset(); #2 reset = 1'b0;
    for (int k = 0; k < 260; k++) begin
      step(1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b0);
      if (k == 254 || k == 255 || k == 259) begin
        total++;
        if (dut_state !== exp_state()) begin
          bad++; $display("FAIL saturate[%0d] got=%h exp=%h", k, dut_state, exp_state());
        end
      end
    end
    total++;
    if (wr_cnt !== 8'hFF) begin
      bad++; $display("FAIL saturate_hold got=%h exp=ff", wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_overwrite();
    test_clear();
    test_collision();
    test_async_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
